// File: rtl/trivium_stream_decrypt.sv
// trivium_stream_decrypt
//   Streaming Trivium decryptor. On start it loads an 80-bit key and IV,
//   runs the 1152-round warm-up at W rounds per cycle, then XORs each
//   accepted W-bit ciphertext beat with the next W keystream bits.
//   Decryption is identical to encryption, so the same keystream is used.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   key, iv              80-bit key / IV (key[i] -> s(i+1), iv[i] -> s(94+i))
//   len                  message length in W-bit words, sampled with start
//   start                begin a message (honoured only while idle)
//   busy, done           busy in every non-idle state; done pulses once at the end
//   ct_valid/ct_ready    ciphertext input handshake, ct_data bit 0 = earliest bit
//   pt_valid/pt_ready    plaintext output handshake, pt_data, pt_last on final beat
module trivium_stream_decrypt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  input  logic [15:0]  len,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [W-1:0] ct_data,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [W-1:0] pt_data,
  output logic         pt_last
);

  localparam int unsigned WARM = 1152 / W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARM,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t       state, state_nx;
  logic [287:0] s;        // s[i-1] holds Trivium state bit s(i)
  logic [287:0] s_next;   // state after W rounds
  logic [W-1:0] z;        // keystream bits of those W rounds, z[0] first
  logic [15:0]  cnt;      // warm-up cycles in WARM, accepted beats in RUN
  logic [15:0]  len_q;
  logic         accept;
  logic         last_beat;
  logic         warm_end;

  // W unrolled Trivium rounds.
  always_comb begin
    logic [287:0] st;
    logic         t1, t2, t3;
    st = s;
    z  = '0;
    for (int unsigned k = 0; k < W; k++) begin
      t1   = st[65]  ^ st[92];
      t2   = st[161] ^ st[176];
      t3   = st[242] ^ st[287];
      z[k] = t1 ^ t2 ^ t3;
      t1   = t1 ^ (st[90]  & st[91])  ^ st[170];
      t2   = t2 ^ (st[174] & st[175]) ^ st[263];
      t3   = t3 ^ (st[285] & st[286]) ^ st[68];
      st   = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
    end
    s_next = st;
  end

  assign accept    = ct_valid && ct_ready;
  assign last_beat = (cnt == len_q - 16'd1);
  assign warm_end  = (cnt == 16'(WARM - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_WARM;
      ST_WARM:  if (warm_end) state_nx = (len_q == 16'd0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (accept && last_beat) state_nx = ST_DRAIN;
      ST_DRAIN: if (pt_valid && pt_ready) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_FIN);
    ct_ready = (state == ST_RUN) && (!pt_valid || pt_ready);
  end

  // Datapath: cipher state, counters and the one-entry output register
  always_ff @(posedge clk) begin
    if (reset) begin
      s        <= '0;
      cnt      <= '0;
      len_q    <= '0;
      pt_data  <= '0;
      pt_valid <= 1'b0;
      pt_last  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            s     <= {3'b111, 108'd0, 4'd0, iv, 13'd0, key};
            len_q <= len;
            cnt   <= '0;
          end
        end
        ST_WARM: begin
          s   <= s_next;
          cnt <= warm_end ? '0 : cnt + 16'd1;
        end
        ST_RUN: begin
          // A new accept reloads the register in the same cycle the old beat
          // leaves, so pt_valid only drops when nothing replaces it.
          if (accept) begin
            pt_data  <= ct_data ^ z;
            pt_valid <= 1'b1;
            pt_last  <= last_beat;
            s        <= s_next;
            cnt      <= cnt + 16'd1;
          end else if (pt_ready) begin
            pt_valid <= 1'b0;
            pt_last  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (pt_valid && pt_ready) begin
            pt_valid <= 1'b0;
            pt_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
